// File: rtl/rgb_channel_sequencer.sv
// rgb_channel_sequencer
// Takes 24-bit RGB pixels over a valid/ready handshake, latches the three
// components and walks one-hot selects R -> G -> B so the downstream byte mux
// emits one byte per accepted byte_ready. Tracks pixel/line position and
// flags the last byte of a line (eol) and of a frame (eof).
module rgb_channel_sequencer #(
  parameter int PIXELS_PER_LINE = 640,
  parameter int LINES_PER_FRAME = 480,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [23:0]      pix_data,
  input  logic             frame_sync,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic             SelR,
  output logic             SelG,
  output logic             SelB,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             eol,
  output logic             eof,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] line_cnt
);

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIXELS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_R = 2'd1,
    SEND_G = 2'd2,
    SEND_B = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   complete;
  logic   sync_pending;

  // A new pixel can be taken when idle, or in the same cycle the blue byte
  // leaves, which is what gives back-to-back 3-cycle pixels.
  assign pix_ready = (state == IDLE) || ((state == SEND_B) && byte_ready);
  assign accept    = pix_valid && pix_ready;
  assign complete  = (state == SEND_B) && byte_ready;

  assign eol = (state == SEND_B) && (pix_cnt == LAST_PIX);
  assign eof = eol && (line_cnt == LAST_LINE);

  // Next-state decode: advance one colour per accepted byte, otherwise hold.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = SEND_R;
      SEND_R: if (byte_ready) state_next = SEND_G;
      SEND_G: if (byte_ready) state_next = SEND_B;
      SEND_B: if (byte_ready) state_next = accept ? SEND_R : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered one-hot selects and byte_valid decoded
  // from the next state, so the outputs leave flops with no glitching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      SelR       <= 1'b0;
      SelG       <= 1'b0;
      SelB       <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      state      <= state_next;
      SelR       <= (state_next == SEND_R);
      SelG       <= (state_next == SEND_G);
      SelB       <= (state_next == SEND_B);
      byte_valid <= (state_next != IDLE);
    end
  end

  // Component latch: only an accepted pixel overwrites the held colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else if (accept) begin
      R <= pix_data[23:16];
      G <= pix_data[15:8];
      B <= pix_data[7:0];
    end
  end

  // Position counters; a frame_sync seen mid-pixel is deferred until that
  // pixel completes so the in-flight pixel still counts in the old frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      sync_pending <= 1'b0;
    end else if (complete) begin
      sync_pending <= 1'b0;
      if (sync_pending || frame_sync) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (pix_cnt == LAST_PIX) begin
        pix_cnt  <= '0;
        line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + CNT_W'(1);
      end else begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
    end else if (frame_sync) begin
      if (state == IDLE) begin
        pix_cnt      <= '0;
        line_cnt     <= '0;
        sync_pending <= 1'b0;
      end else begin
        sync_pending <= 1'b1;
      end
    end
  end

endmodule
